div_stage: RTL

Multi-cycle RV32M divide unit for the execute stage. It runs alongside the ALU and multiplier and takes the same `EX_A`/`EX_B` operands plus the ROB tag of the issuing instruction. Unsigned magnitudes are divided by restoring radix-2 division, one quotient bit per cycle. It returns a single-cycle completion pulse with result, destination register, ROB tag and `PC_plus4`, which feeds the E/M-R writeback mux ahead of the ROB.

---
 rtl/div_stage.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/div_stage.sv
// Purpose : multi-cycle RV32M divide/remainder unit (DIV, DIVU, REM, REMU), restoring radix-2.
// Latency : 34 cycles from accept to div_done (32 CALC + FIX + DONE); 1 cycle for divide-by-zero/overflow.
// Backpr. : none downstream; div_done must be taken when pulsed. Upstream stalls on busy.
//
// Ports
//   clk, rstn            clock (rising edge), asynchronous active-low reset
//   div_en, funct3       start request and op select (00 DIV, 01 DIVU, 10 REM, 11 REMU)
//   r_RD1, r_RD2         dividend, divisor
//   tailE, r_WA,         ROB tag, destination register and PC+4 of the issuing instruction
//   PC_plus4E
//   kill                 flush: aborts an in-flight (CALC/FIX) divide
//   busy, r_WA_busy      unit occupied / destination of the in-flight divide (0 when idle)
//   div_done             one-cycle completion pulse
//   r_WA_DU, tail_DU,    completion sideband and quotient/remainder, valid with div_done
//   PC_plus4DU, result
module div_stage #(
  parameter int XLEN = 32,
  parameter int TAG  = 7
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            div_en,
  input  logic [1:0]      funct3,
  input  logic [XLEN-1:0] r_RD1,
  input  logic [XLEN-1:0] r_RD2,
  input  logic [TAG-1:0]  tailE,
  input  logic [4:0]      r_WA,
  input  logic [31:0]     PC_plus4E,
  input  logic            kill,
  output logic            busy,
  output logic [4:0]      r_WA_busy,
  output logic            div_done,
  output logic [4:0]      r_WA_DU,
  output logic [TAG-1:0]  tail_DU,
  output logic [31:0]     PC_plus4DU,
  output logic [XLEN-1:0] result
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [5:0]      LAST_ITER = 6'(XLEN - 1);
  localparam logic [XLEN-1:0] INT_MIN   = {1'b1, {(XLEN-1){1'b0}}};

  // ------------------------------------------------------------------
  // State
  // ------------------------------------------------------------------
  logic [1:0]      state_q, state_d;
  logic [5:0]      cnt_q;
  logic [XLEN-1:0] rem_q;      // partial remainder
  logic [XLEN-1:0] quo_q;      // dividend shifts out of the top, quotient bits enter at the bottom
  logic [XLEN-1:0] dvs_q;      // divisor magnitude
  logic            neg_quo_q;
  logic            neg_rem_q;
  logic            sel_rem_q;
  logic [4:0]      wa_q;
  logic [TAG-1:0]  tag_q;
  logic [31:0]     pc_q;
  logic [XLEN-1:0] result_q;
  logic            done_q;
  logic            busy_q;
  logic [4:0]      wa_busy_q;

  // ------------------------------------------------------------------
  // Accept-side decode
  // ------------------------------------------------------------------
  logic            is_signed;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic            div_zero;
  logic            overflow;
  logic            special;
  logic [XLEN-1:0] special_res;
  logic            can_accept;
  logic            accept;

  assign is_signed = ~funct3[0];
  assign a_neg     = is_signed & r_RD1[XLEN-1];
  assign b_neg     = is_signed & r_RD2[XLEN-1];
  assign a_mag     = a_neg ? -r_RD1 : r_RD1;
  assign b_mag     = b_neg ? -r_RD2 : r_RD2;

  assign div_zero  = (r_RD2 == '0);
  assign overflow  = is_signed & (r_RD1 == INT_MIN) & (r_RD2 == '1);
  assign special   = div_zero | overflow;

  // Divide-by-zero wins over overflow (the overflow divisor is -1, never 0).
  always_comb begin
    special_res = '0;
    if (div_zero) begin
      special_res = funct3[1] ? r_RD1 : '1;
    end else begin
      special_res = funct3[1] ? '0 : INT_MIN;
    end
  end

  // kill blocks a start in the same cycle, including in DONE.
  assign can_accept = (state_q == S_IDLE) | (state_q == S_DONE);
  assign accept     = can_accept & div_en & ~kill;

  // ------------------------------------------------------------------
  // One restoring iteration
  // ------------------------------------------------------------------
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;
  logic            fits;
  logic [XLEN-1:0] rem_step;
  logic [XLEN-1:0] quo_step;

  assign shifted  = {rem_q, quo_q[XLEN-1]};
  assign diff     = shifted - {1'b0, dvs_q};
  // The remainder stays below the divisor, so a borrow shows up as the top bit.
  assign fits     = ~diff[XLEN];
  assign rem_step = fits ? diff[XLEN-1:0] : shifted[XLEN-1:0];
  assign quo_step = {quo_q[XLEN-2:0], fits};

  // ------------------------------------------------------------------
  // Sign fix-up and result select
  // ------------------------------------------------------------------
  logic [XLEN-1:0] quo_fix;
  logic [XLEN-1:0] rem_fix;
  logic [XLEN-1:0] fix_res;

  assign quo_fix = neg_quo_q ? -quo_q : quo_q;
  assign rem_fix = neg_rem_q ? -rem_q : rem_q;
  assign fix_res = sel_rem_q ? rem_fix : quo_fix;

  // ------------------------------------------------------------------
  // Next state
  // ------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = special ? S_DONE : S_CALC;
      end
      S_CALC: begin
        if (kill)                    state_d = S_IDLE;
        else if (cnt_q == LAST_ITER) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = kill ? S_IDLE : S_DONE;
      end
      S_DONE: begin
        // Back-to-back issue re-enters the datapath directly.
        if (accept) state_d = special ? S_DONE : S_CALC;
        else        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  logic       busy_d;
  logic [4:0] wa_d;

  assign busy_d = (state_d == S_CALC) | (state_d == S_FIX);
  assign wa_d   = accept ? r_WA : wa_q;

  // ------------------------------------------------------------------
  // Registers
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      sel_rem_q <= 1'b0;
      wa_q      <= '0;
      tag_q     <= '0;
      pc_q      <= '0;
      result_q  <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      wa_busy_q <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      wa_busy_q <= busy_d ? wa_d : 5'd0;
      done_q    <= (state_d == S_DONE);

      if (accept) begin
        cnt_q     <= '0;
        rem_q     <= '0;
        quo_q     <= a_mag;
        dvs_q     <= b_mag;
        neg_quo_q <= a_neg ^ b_neg;
        neg_rem_q <= a_neg;
        sel_rem_q <= funct3[1];
        wa_q      <= r_WA;
        tag_q     <= tailE;
        pc_q      <= PC_plus4E;
        if (special) result_q <= special_res;
      end else if (state_q == S_CALC) begin
        cnt_q <= cnt_q + 6'd1;
        rem_q <= rem_step;
        quo_q <= quo_step;
      end else if ((state_q == S_FIX) && !kill) begin
        result_q <= fix_res;
      end
    end
  end

  // ------------------------------------------------------------------
  // Outputs (all straight from flops)
  // ------------------------------------------------------------------
  assign busy       = busy_q;
  assign r_WA_busy  = wa_busy_q;
  assign div_done   = done_q;
  assign r_WA_DU    = wa_q;
  assign tail_DU    = tag_q;
  assign PC_plus4DU = pc_q;
  assign result     = result_q;

endmodule
